// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared constants and helpers for the seven-segment display blocks.
//   SEG_BLANK     : active-low segment pattern with every segment off
//   ANODE_OFF     : active-low anode pattern with every digit off
//   PHASE_FIRST   : ring-counter phase that marks the start of a frame
//   HEX_SEG_TABLE : nibble -> active-low {g,f,e,d,c,b,a} pattern
//   is_onehot4    : true when exactly one bit of a 4-bit vector is set
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK   = 7'h7F;
    localparam logic [3:0] ANODE_OFF   = 4'hF;
    localparam logic [3:0] PHASE_FIRST = 4'b0001;

    // Index 0 is the first element: entry n is the pattern for hex digit n.
    localparam logic [6:0] HEX_SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // v & (v - 1) clears the lowest set bit, so it is zero only for
    // vectors with at most one bit set; the non-zero test excludes 0000.
    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/seg7_scan_driver_hex_to_seg7.sv
// hex_to_seg7
// Combinational hex nibble to active-low seven-segment decoder.
//   i_nibble : 4-bit value to display
//   o_seg    : active-low segments {g,f,e,d,c,b,a}
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = HEX_SEG_TABLE[i_nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Four-digit time-multiplexed seven-segment driver. The digit strobe is the
// one-hot phase of an upstream ring counter. Display values arrive over a
// valid/ready handshake into a one-entry pending buffer and are committed to
// the shown value only at frame boundaries, so a half-updated number is
// never displayed.
//
// Handshake: a value transfers on a clock edge where i_wr_valid and
// o_wr_ready are both 1. o_wr_ready is 1 exactly when the pending buffer is
// empty; a sender seeing o_wr_ready=0 must hold i_wr_valid and i_wr_data.
//
//   clk, rst        : clock, synchronous active-high reset
//   i_phase         : one-hot digit strobe (0001 -> 1000 -> 0100 -> 0010)
//   i_wr_valid      : write request
//   i_wr_data       : value to display, nibble i is digit i
//   o_wr_ready      : pending buffer empty
//   i_blank_lz      : leading-zero suppression enable
//   o_an            : active-low anodes, o_an[i] selects digit i
//   o_seg           : active-low segments {g,f,e,d,c,b,a}
//   o_frame_start   : one-cycle pulse for each frame boundary
//   o_phase_err     : sticky flag for a non-one-hot phase
module seg7_scan_driver
    import seg7_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  i_phase,
    input  logic        i_wr_valid,
    input  logic [15:0] i_wr_data,
    output logic        o_wr_ready,
    input  logic        i_blank_lz,
    output logic [3:0]  o_an,
    output logic [6:0]  o_seg,
    output logic        o_frame_start,
    output logic        o_phase_err
);

    logic [15:0] r_disp;
    logic [15:0] r_pend;
    logic        r_pend_full;
    logic [3:0]  r_prev_phase;
    logic        r_wr_ready;
    logic [3:0]  r_an;
    logic [6:0]  r_seg;
    logic        r_frame_start;
    logic        r_phase_err;

    logic        w_onehot;
    logic        w_boundary;
    logic        w_accept;
    logic        w_commit;
    logic        w_pend_full_nxt;
    logic [15:0] w_disp_nxt;
    logic [3:0]  w_nibble;
    logic        w_blank;
    logic [6:0]  w_dec_seg;
    logic [6:0]  w_seg_nxt;
    logic [3:0]  w_an_nxt;

    assign w_onehot   = is_onehot4(i_phase);
    // Edge into PHASE_FIRST, so a held 0001 yields a single boundary.
    assign w_boundary = (i_phase == PHASE_FIRST) && (r_prev_phase != PHASE_FIRST);
    assign w_accept   = i_wr_valid && r_wr_ready;
    // Uses pend_full from before this cycle's write, so a write landing on
    // a boundary waits for the following one.
    assign w_commit   = w_boundary && r_pend_full;

    // Accept and commit are mutually exclusive: accept needs an empty
    // buffer, commit needs a full one.
    assign w_pend_full_nxt = w_accept ? 1'b1 : (w_commit ? 1'b0 : r_pend_full);

    // The boundary cycle already shows the committed value.
    assign w_disp_nxt = w_commit ? r_pend : r_disp;

    // Digit select and leading-zero blanking. Digit 0 is never blanked.
    always_comb begin
        w_nibble = w_disp_nxt[3:0];
        w_blank  = 1'b0;
        unique case (i_phase)
            4'b0010: begin
                w_nibble = w_disp_nxt[7:4];
                w_blank  = i_blank_lz && (w_disp_nxt[15:4] == 12'd0);
            end
            4'b0100: begin
                w_nibble = w_disp_nxt[11:8];
                w_blank  = i_blank_lz && (w_disp_nxt[15:8] == 8'd0);
            end
            4'b1000: begin
                w_nibble = w_disp_nxt[15:12];
                w_blank  = i_blank_lz && (w_disp_nxt[15:12] == 4'd0);
            end
            default: begin
                w_nibble = w_disp_nxt[3:0];
                w_blank  = 1'b0;
            end
        endcase
    end

    hex_to_seg7 u_hex_to_seg7 (
        .i_nibble (w_nibble),
        .o_seg    (w_dec_seg)
    );

    always_comb begin
        w_an_nxt  = ANODE_OFF;
        w_seg_nxt = SEG_BLANK;
        if (w_onehot) begin
            w_an_nxt  = ~i_phase;
            w_seg_nxt = w_blank ? SEG_BLANK : w_dec_seg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_disp        <= 16'd0;
            r_pend        <= 16'd0;
            r_pend_full   <= 1'b0;
            r_prev_phase  <= 4'd0;
            r_wr_ready    <= 1'b0;
            r_an          <= ANODE_OFF;
            r_seg         <= SEG_BLANK;
            r_frame_start <= 1'b0;
            r_phase_err   <= 1'b0;
        end else begin
            r_disp        <= w_disp_nxt;
            if (w_accept) begin
                r_pend    <= i_wr_data;
            end
            r_pend_full   <= w_pend_full_nxt;
            r_prev_phase  <= i_phase;
            r_wr_ready    <= !w_pend_full_nxt;
            r_an          <= w_an_nxt;
            r_seg         <= w_seg_nxt;
            r_frame_start <= w_boundary;
            r_phase_err   <= r_phase_err || !w_onehot;
        end
    end

    assign o_wr_ready    = r_wr_ready;
    assign o_an          = r_an;
    assign o_seg         = r_seg;
    assign o_frame_start = r_frame_start;
    assign o_phase_err   = r_phase_err;

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Four-digit, time-multiplexed seven-segment display driver that sits directly downstream of the 4-bit ring counter. It consumes the ring counter's rotating one-hot phase as the digit-select strobe and accepts 16-bit display values over a valid/ready handshake. New values are held in a pending buffer and committed atomically at frame boundaries, so a partially updated number never appears on the display. It drives active-low anodes and active-low segments, and flags any illegal (non-one-hot) phase.

## Interface
- No parameters; the design is fixed at 4 digits, hex encoding.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- phase  in  4  one-hot digit strobe from the ring counter (rotates 0001→1000→0100→0010)
- wr_valid  in  1  write request
- wr_data  in  16  value to display; nibble i is digit i
- wr_ready  out  1  pending buffer empty, write can be accepted
- blank_lz  in  1  enables leading-zero suppression
- an  out  4  anode enables, active-low; an[i] selects digit i
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- frame_start  out  1  one-cycle pulse on each frame boundary
- phase_err  out  1  sticky flag for a non-one-hot phase; cleared only by rst

## Operation
- Registers: disp[15:0] (shown value), pend[15:0] plus pend_full, prev_phase[3:0], and the output registers.
- Handshake:
  - wr_ready = !pend_full, registered.
  - A transfer occurs when wr_valid && wr_ready; it loads pend and sets pend_full.
  - wr_valid with wr_ready=0 is ignored; the sender must hold the request.
- Frame boundary: phase==4'b0001 && prev_phase!=4'b0001.
  - prev_phase resets to 0000, so the first 0001 after reset counts as a boundary.
  - At a boundary with pend_full: disp<=pend, pend_full<=0.
  - frame_start is asserted for that cycle's registered output.
- Simultaneous transfer and boundary: the new data goes to pend and commits at the *next* boundary. The boundary sees pend_full as it was before the write.
- Digit select: phase[i]=1 selects nibble disp[4i+3:4i] and drives an[i]=0, all other anodes 1.
- Hex decode (active-low gfedcba):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex values)
- Leading zeros: with blank_lz=1, digit i (i≥1) is blanked when all nibbles i..3 of disp are zero. Blanking drives seg=7F; the anode stays active. Digit 0 is never blanked.
- Illegal phase (zero bits or more than one bit set):
  - an=1111, seg=7F for that cycle.
  - phase_err<=1, which holds until rst.
  - A non-one-hot phase is not a boundary.
- Reset values: disp=0000, pend_full=0, wr_ready=0 during rst and 1 from the first cycle after it, an=F, seg=7F, frame_start=0, phase_err=0, prev_phase=0.

## Timing
- Latency from phase to an/seg/frame_start is 1 cycle; all outputs are registered.
- A value accepted at cycle t appears on the display starting at the first boundary after t. It is visible on an/seg one cycle after that boundary cycle.
- wr_ready falls the cycle after acceptance and rises the cycle after the committing boundary.
- Maximum sustained write rate is one value per frame (4 phase steps).
- rst mid-frame or mid-write: pend and disp are discarded, and the outputs go to their reset values on the next edge.
- phase may advance every cycle or be held. Holding phase at 0001 produces exactly one boundary.

## Structure
- Shared package seg7_pkg:
  - SEG_BLANK = 7'h7F, ANODE_OFF = 4'hF, PHASE_FIRST = 4'b0001.
  - The hex-to-segment constant table.
- Sub-module hex_to_seg7: combinational 4-bit to 7-bit active-low decoder, reused by other display blocks.
- The top module holds the handshake, pending buffer, boundary detect, one-hot check, blanking mux and output registers.

## Test plan
- Reset, then phase 0001: an=E, seg=40 (digit 0 shows "0"), frame_start=1, wr_ready=1.
- Write 16'h1234 mid-frame, then cycle phase 0001,1000,0100,0010. Digit 0 shows old 0 until the boundary, then the outputs are an=E/seg=19, an=7/seg=79, an=B/seg=24, an=D/seg=30. wr_ready stays 0 until the commit.
- blank_lz=1 with 16'h0050: digit 0 seg=40, digit 1 seg=12, digits 2 and 3 seg=7F with their anodes active.
- Back-to-back writes A then B within one frame: B is held with wr_ready=0. The display shows A after boundary 1 and B after boundary 2.
- phase=4'b0101: an=F, seg=7F, phase_err=1 and staying 1 through later legal phases until rst.
- Write and boundary in the same cycle: the value appears only after the following boundary. Asserting rst mid-frame restores disp=0000, an=F and phase_err=0.
